// File: rtl/gemm_acc_drain_pkg.sv
// Shared constants and state encoding for the accumulator drain engine.
// Bank count and word size mirror the GEMM datapath accumulator interface.
package gemm_acc_drain_pkg;

  localparam int ACC_NUM        = 4;
  localparam int ACC_DATA_W     = 128;
  localparam int ACC_WORD_BYTES = 16;
  localparam int ACC_WORD_SHIFT = $clog2(ACC_WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/drain_out_fifo.sv
// Small {addr,data} FIFO between the bank read port and the write stream.
// Push and pop may coincide at any occupancy; storage clears on reset.
module drain_out_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign head_data = mem_reg[rd_ptr_reg];

  // A pop frees the head slot in the same cycle, so push into a full FIFO is fine.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/gemm_acc_drain.sv
// Drains the accumulator banks row-major (bank 0..3 per row) into a
// valid/ready write stream, with a credit check so the output FIFO never overflows.
module gemm_acc_drain
  import gemm_acc_drain_pkg::*;
#(
  parameter int NUM_ACC   = ACC_NUM,
  parameter int DATA_W    = ACC_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int ROWS_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         row_stride,
  input  logic [ROWS_W-1:0]         num_rows,
  input  logic [NUM_ACC-1:0]        acc_empty,
  output logic [NUM_ACC-1:0]        accums_rd_en,
  input  logic [NUM_ACC*DATA_W-1:0] accum_o_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_data,
  output logic                      busy,
  output logic                      done
);

  localparam int BANK_W = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int ENT_W  = ADDR_W + DATA_W;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_ACC - 1);

  drain_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [ROWS_W-1:0] rows_reg;
  logic [ROWS_W-1:0] row_cnt_reg;
  logic [BANK_W-1:0] bank_reg;
  logic              inflight_reg;
  logic [BANK_W-1:0] inflight_bank_reg;
  logic [ADDR_W-1:0] inflight_addr_reg;

  logic [DATA_W-1:0] bank_data [NUM_ACC];
  logic [ADDR_W-1:0] issue_addr;
  logic              issue;
  logic              last_read;
  logic              credit_ok;
  logic [CNT_W:0]    credit_used;
  logic              flush_clear;

  logic              fifo_pop;
  logic [ENT_W-1:0]  fifo_push_data;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACC; gi++) begin : g_bank
      assign bank_data[gi]    = accum_o_data[gi*DATA_W +: DATA_W];
      assign accums_rd_en[gi] = issue && (bank_reg == BANK_W'(gi));
    end
  endgenerate

  // Row base is accumulated per row; the bank offset is a constant shift.
  assign issue_addr = row_base_reg + (ADDR_W'(bank_reg) << ACC_WORD_SHIFT);
  assign last_read  = (bank_reg == LAST_BANK) && (row_cnt_reg == rows_reg - ROWS_W'(1));

  // Occupancy counts the word leaving this cycle, which keeps reads flowing at 1/cycle.
  assign fifo_pop    = m_valid && m_ready;
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_reg) - (CNT_W+1)'(fifo_pop);
  assign credit_ok   = (credit_used < (CNT_W+1)'(BUF_DEPTH)) && !(fifo_full && !fifo_pop);
  assign issue       = (state_reg == DRAIN) && !acc_empty[bank_reg] && credit_ok;
  assign flush_clear = !inflight_reg && (fifo_count == CNT_W'(fifo_pop));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_rows == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (issue && last_read) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_clear) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= IDLE;
      row_base_reg      <= '0;
      stride_reg        <= '0;
      rows_reg          <= '0;
      row_cnt_reg       <= '0;
      bank_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_bank_reg <= '0;
      inflight_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (issue) begin
        inflight_bank_reg <= bank_reg;
        inflight_addr_reg <= issue_addr;
      end
      if (state_reg == IDLE && start) begin
        row_base_reg <= base_addr;
        stride_reg   <= row_stride;
        rows_reg     <= num_rows;
        row_cnt_reg  <= '0;
        bank_reg     <= '0;
      end else if (issue) begin
        if (bank_reg == LAST_BANK) begin
          bank_reg     <= '0;
          row_cnt_reg  <= row_cnt_reg + ROWS_W'(1);
          row_base_reg <= row_base_reg + stride_reg;
        end else begin
          bank_reg <= bank_reg + BANK_W'(1);
        end
      end
    end
  end

  // Bank data arrives one cycle after its strobe and is captured with the address issued then.
  assign fifo_push_data = {inflight_addr_reg, bank_data[inflight_bank_reg]};

  drain_out_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (BUF_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid          = !fifo_empty;
  assign {m_addr, m_data} = fifo_head;
  assign busy             = (state_reg != IDLE);
  assign done             = (state_reg == DONE);

endmodule

// File: tb/tb_gemm_acc_drain.sv
// Bench for gemm_acc_drain: bank model, scoreboard of expected writes,
// vector table of drains plus stall and reset sequences.
module tb_gemm_acc_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [31:0]  row_stride;
  logic [15:0]  num_rows;
  logic [3:0]   acc_empty = 4'b0;
  logic [3:0]   accums_rd_en;
  logic [511:0] accum_o_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_addr;
  logic [127:0] m_data;
  logic         busy;
  logic         done;

  logic [127:0] bank_data [4];
  assign accum_o_data = {bank_data[3], bank_data[2], bank_data[1], bank_data[0]};

  always #5 clk = ~clk;

  gemm_acc_drain dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .row_stride   (row_stride),
    .num_rows     (num_rows),
    .acc_empty    (acc_empty),
    .accums_rd_en (accums_rd_en),
    .accum_o_data (accum_o_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_addr       (m_addr),
    .m_data       (m_data),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    logic [15:0] rows;
    logic [31:0] base;
    logic [31:0] stride;
    int          rmode;
    int          exp_words;
    logic [31:0] exp_last;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt[4];
  int age[4];
  int issued, accepted, first_rd, first_val, valid_cycles;
  int done_cnt, done_cyc, last_acc_cyc, start_cyc;
  logic [31:0] last_acc_addr;
  int ready_mode = 0;
  int stall_left = 0;
  int stall_bank = 2;
  bit prev_hold = 1'b0;
  logic [31:0] prev_addr;
  logic [127:0] prev_data;

  function automatic logic [127:0] word_of(input int b, input int i);
    return {8'(8'hA0 + b), 24'(i), 32'(i * 977 + 13), 32'h5EED_0000 | 32'(b), 32'(~i)};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic clear_stats();
    for (int b = 0; b < 4; b++) begin
      rd_cnt[b] = 0;
      age[b] = 3;
    end
    issued = 0;
    accepted = 0;
    first_rd = -1;
    first_val = -1;
    valid_cycles = 0;
    done_cnt = 0;
    done_cyc = -1;
    last_acc_cyc = -1;
    last_acc_addr = '0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write-stream backpressure and bank-empty stimulus.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = !(((cyc - start_cyc) >= 6) && ((cyc - start_cyc) < 16));
      default: m_ready = 1'b0;
    endcase
    acc_empty = (stall_left > 0) ? 4'(1 << stall_bank) : 4'b0;
    if (stall_left > 0) stall_left--;
  end

  // Bank model, stream monitor and scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      chk($onehot0(accums_rd_en), "rd_en_onehot", 128'(accums_rd_en), 128'(0));
      chk((accums_rd_en & acc_empty) == 4'b0, "rd_on_empty_bank", 128'(accums_rd_en), 128'(acc_empty));
      if (acc_empty[2] && rd_cnt[1] > rd_cnt[2])
        chk(accums_rd_en == 4'b0, "stall_no_rd", 128'(accums_rd_en), 128'(0));
      for (int b = 0; b < 4; b++) begin
        if (accums_rd_en[b]) begin
          bank_data[b] = word_of(b, rd_cnt[b]);
          rd_cnt[b]++;
          age[b] = 0;
        end else begin
          if (age[b] == 2) bank_data[b] = {4{32'hBAD0_BAD0}};
          if (age[b] < 3) age[b]++;
        end
      end
      issued += $countones(accums_rd_en);
      if (accums_rd_en != 4'b0 && first_rd < 0) first_rd = cyc;
      if (m_valid && first_val < 0) first_val = cyc;
      if (m_valid) valid_cycles++;
      if (prev_hold) begin
        chk(m_valid == 1'b1, "hold_valid", 128'(m_valid), 128'(1));
        chk(m_addr == prev_addr, "hold_addr", 128'(m_addr), 128'(prev_addr));
        chk(m_data == prev_data, "hold_data", m_data, prev_data);
      end
      if (m_valid && m_ready) begin
        accepted++;
        last_acc_cyc = cyc;
        last_acc_addr = m_addr;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", 128'(m_addr), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("write #%0d addr=%h data=%h exp_addr=%h", accepted, m_addr, m_data, e.addr);
          chk(m_addr == e.addr, "write_addr", 128'(m_addr), 128'(e.addr));
          chk(m_data == e.data, "write_data", m_data, e.data);
        end
      end
      chk((issued - accepted) <= 2, "buffer_bound", 128'(issued - accepted), 128'(2));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = m_valid && !m_ready;
      prev_addr = m_addr;
      prev_data = m_data;
    end
  end

  task automatic run_drain(input logic [15:0] rows, input logic [31:0] base, input logic [31:0] stride,
                           input int rmode, input bit extra, input int stall_cycles,
                           output int words, output logic [31:0] last_addr);
    int exp_done;
    @(posedge clk);
    #1;
    clear_stats();
    ready_mode = rmode;
    if (stall_cycles > 0) stall_left = stall_cycles;
    @(posedge clk);
    #1;
    base_addr = base;
    row_stride = stride;
    num_rows = rows;
    start = 1'b1;
    start_cyc = cyc;
    for (int r = 0; r < int'(rows); r++) begin
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back('{base + 32'(r) * stride + 32'(b * 16), word_of(b, r)});
      end
    end
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      start = extra && (i % 5 == 2);
      if (start) begin
        base_addr = $urandom;
        num_rows = 16'd7;
      end
      @(negedge clk);
      #1;
      chk(busy == 1'b1, "busy_high", 128'(busy), 128'(1));
      if (done_cnt != 0) break;
    end
    start = 1'b0;
    chk(done_cnt != 0, "done_seen", 128'(done_cnt), 128'(1));
    @(negedge clk);
    #1;
    exp_done = (rows == 16'd0) ? start_cyc + 1 : last_acc_cyc + 1;
    chk(done_cnt == 1, "done_once", 128'(done_cnt), 128'(1));
    chk(done_cyc == exp_done, "done_cycle", 128'(done_cyc), 128'(exp_done));
    chk(busy == 1'b0, "busy_low_after", 128'(busy), 128'(0));
    chk(exp_q.size() == 0, "words_missing", 128'(exp_q.size()), 128'(0));
    if (rows != 16'd0) begin
      chk(first_rd == start_cyc + 1, "first_rd_latency", 128'(first_rd), 128'(start_cyc + 1));
      chk(first_val == start_cyc + 3, "first_valid_latency", 128'(first_val), 128'(start_cyc + 3));
    end else begin
      chk(first_rd == -1, "zero_rows_no_rd", 128'(first_rd), 128'(-1));
      chk(valid_cycles == 0, "zero_rows_no_valid", 128'(valid_cycles), 128'(0));
    end
    exp_q.delete();
    words = accepted;
    last_addr = last_acc_addr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] la;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_stride = '0;
    num_rows = '0;
    for (int b = 0; b < 4; b++) bank_data[b] = '0;
    clear_stats();
    start_cyc = 0;

    vecs[0] = '{16'd2, 32'h0000_1000, 32'h0000_0100, 0, 8,  32'h0000_1130};
    vecs[1] = '{16'd3, 32'h0000_2000, 32'h0000_0040, 2, 12, 32'h0000_20B0};
    vecs[2] = '{16'd1, 32'hFFFF_FFF0, 32'h0000_0010, 0, 4,  32'h0000_0020};
    vecs[3] = '{16'd5, 32'h0000_0000, 32'h0001_0000, 1, 20, 32'h0004_0030};
    vecs[4] = '{16'd0, 32'h0000_0500, 32'h0000_0000, 0, 0,  32'h0000_0000};

    #2 rst = 1'b0;
    #1;
    chk(accums_rd_en == 4'b0, "reset_rd_en", 128'(accums_rd_en), 128'(0));
    chk(m_valid == 1'b0, "reset_valid", 128'(m_valid), 128'(0));
    chk(m_addr == 32'h0, "reset_addr", 128'(m_addr), 128'(0));
    chk(m_data == 128'h0, "reset_data", m_data, 128'(0));
    chk(busy == 1'b0, "reset_busy", 128'(busy), 128'(0));
    chk(done == 1'b0, "reset_done", 128'(done), 128'(0));
    @(negedge clk);
    #2 rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_drain(vecs[k].rows, vecs[k].base, vecs[k].stride, vecs[k].rmode, 1'b0, 0, w, la);
      $display("vector %0d rows=%0d words=%0d last_addr=%h", k, vecs[k].rows, w, la);
      chk(w == vecs[k].exp_words, $sformatf("vec%0d_words", k), 128'(w), 128'(vecs[k].exp_words));
      if (vecs[k].exp_words > 0)
        chk(la == vecs[k].exp_last, $sformatf("vec%0d_last_addr", k), 128'(la), 128'(vecs[k].exp_last));
    end

    // Bank 2 empty across row 0: order must stay strict.
    stall_bank = 2;
    run_drain(16'd2, 32'h0000_3000, 32'h0000_0080, 0, 1'b0, 10, w, la);
    $display("stall run words=%0d last_addr=%h", w, la);
    chk(w == 8, "stall_words", 128'(w), 128'(8));
    chk(la == 32'h0000_30B0, "stall_last_addr", 128'(la), 128'(32'h0000_30B0));

    // Fill the buffer with the stream blocked, then reset mid-drain.
    @(posedge clk);
    #1;
    clear_stats();
    ready_mode = 3;
    base_addr = 32'h0000_8000;
    row_stride = 32'h0000_0040;
    num_rows = 16'd4;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk(m_valid == 1'b1, "full_valid", 128'(m_valid), 128'(1));
    chk(issued == 2, "full_issued", 128'(issued), 128'(2));
    chk(accums_rd_en == 4'b0, "full_rd_stopped", 128'(accums_rd_en), 128'(0));
    chk(m_addr == 32'h0000_8000, "full_head_addr", 128'(m_addr), 128'(32'h0000_8000));
    rst = 1'b0;
    #1;
    $display("reset mid-drain: rd_en=%b valid=%b addr=%h busy=%b done=%b", accums_rd_en, m_valid, m_addr, busy, done);
    chk(accums_rd_en == 4'b0, "midrst_rd_en", 128'(accums_rd_en), 128'(0));
    chk(m_valid == 1'b0, "midrst_valid", 128'(m_valid), 128'(0));
    chk(m_addr == 32'h0, "midrst_addr", 128'(m_addr), 128'(0));
    chk(m_data == 128'h0, "midrst_data", m_data, 128'(0));
    chk(busy == 1'b0, "midrst_busy", 128'(busy), 128'(0));
    chk(done == 1'b0, "midrst_done", 128'(done), 128'(0));
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    ready_mode = 0;

    // Fresh drain after reset, with stray starts while busy.
    run_drain(16'd3, 32'h0000_9000, 32'h0000_0200, 1, 1'b1, 0, w, la);
    $display("post-reset run words=%0d last_addr=%h", w, la);
    chk(w == 12, "post_reset_words", 128'(w), 128'(12));
    chk(la == 32'h0000_9430, "post_reset_last_addr", 128'(la), 128'(32'h0000_9430));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
